interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Owns the interrupt enable (IE), interrupt flag (IF) and master enable (IME) state, and schedules interrupt dispatch into the control unit at instruction boundaries. Latches peripheral requests (VBlank, STAT, Timer, Serial, Joypad) and selects the highest-priority pending source. Runs a handshake with the control unit, which performs the PC push and jump while this block supplies the vector. Also generates the HALT wake signal.

## Interface
Parameters:
- NUM_SRC, 5, number of interrupt sources; bit 0 has the highest priority.
- VEC_BASE, 16'h0040, vector of source 0; source n vectors to VEC_BASE + 8*n.

Ports:
- i_Clk  in  1  system clock.
- i_Reset_n  in  1  reset, asynchronous, active-low.
- i_Enable  in  1  T-cycle enable; all state updates are gated by it.
- i_Request  in  5  peripheral request pulses; each sets its IF bit.
- i_Data  in  8  register write data.
- i_IF_Write  in  1  write i_Data[4:0] to IF.
- i_IE_Write  in  1  write i_Data to IE (all 8 bits stored).
- o_IF  out  8  IF read value, {3'b111, IF[4:0]}.
- o_IE  out  8  IE read value.
- i_EI  in  1  EI executing: delayed IME set.
- i_DI  in  1  DI executing: immediate IME clear.
- i_RETI  in  1  RETI executing: immediate IME set.
- i_Boundary  in  1  one-cycle pulse when the control unit finishes an instruction and is about to fetch.
- i_Ack  in  1  control unit has pushed the PC high byte and requests the vector.
- i_Done  in  1  control unit has completed the jump.
- o_Handle_Interrupt  out  1  dispatch requested; control unit enters the dispatch sequence instead of the fetch.
- o_Vector  out  16  target address; valid in state VECTOR.
- o_Wake  out  1  (IE & IF & 5'h1F) != 0, combinational, independent of IME.

## Operation
- Reset values:
  - IE = 8'h00, IF = 5'h00 (o_IF = 8'hE0).
  - IME = 0, ei_pending = 0, state IDLE.
  - o_Handle_Interrupt = 0, o_Vector = 16'h0000, o_Wake = 0.
- IF update order within an enabled cycle: register write, then clear-on-ack, then OR in i_Request. A request always wins against a same-cycle clear or write of the same bit.
- IME:
  - i_EI sets ei_pending. At the next i_Boundary, IME <= 1 and ei_pending <= 0. The dispatch check at that boundary uses the old IME, so the instruction after EI always executes.
  - i_DI clears IME and ei_pending. If i_EI and i_DI are asserted in the same cycle, DI wins.
  - i_RETI sets IME immediately.
- FSM:
  - IDLE -> DISPATCH on i_Boundary & IME & pending != 0, where pending = IE[4:0] & IF. Sets IME <= 0.
  - DISPATCH: o_Handle_Interrupt = 1. On i_Ack, latch the winner, clear its IF bit, load o_Vector, and go to VECTOR.
  - Cancellation: if pending == 0 at i_Ack (for example, IE was overwritten by the push), o_Vector = 16'h0000, no IF bit is cleared, and the state goes to VECTOR.
  - VECTOR -> IDLE on i_Done. o_Vector holds until the next i_Ack.
- Priority: lowest set bit of pending wins.
- i_Boundary seen outside IDLE is ignored.
- Reset mid-dispatch returns everything to reset values immediately.

## Timing
- o_Handle_Interrupt is registered and rises the first enabled cycle after the qualifying i_Boundary. It falls on the enabled cycle after i_Ack.
- o_Vector is valid from the enabled cycle after i_Ack.
- An i_Request pulse is visible in o_IF and o_Wake one enabled cycle later.
- When i_Enable = 0, all state holds and requests are not captured. Peripherals must hold requests across disabled cycles.

## Configuration
- IC_LATE_VECTOR_EN:
  - Defined: the winner is selected at i_Ack, and cancellation is possible (hardware-accurate).
  - Undefined: the winner is latched at the IDLE->DISPATCH transition and its IF bit is cleared then. i_Ack only loads o_Vector, and a vector of 16'h0000 never occurs.

## Structure
- Package gb_int_pkg holds:
  - the state enum (IDLE, DISPATCH, VECTOR);
  - source bit indices (INT_VBLANK=0, INT_STAT=1, INT_TIMER=2, INT_SERIAL=3, INT_JOYPAD=4);
  - the VEC_BASE and vector stride constants.
- One sub-module, int_priority_encoder: a 5-bit one-hot winner plus 3-bit index, with a valid flag.

## Test plan
- IE=8'h05, IME=1, pulse i_Request[2] then i_Boundary -> o_Handle_Interrupt=1 next cycle. After i_Ack, o_Vector=16'h0050, IF=5'h00, IME=0.
- IE=8'h1F, request bits 4 and 1 together, dispatch -> o_Vector=16'h0048, IF=5'h10. A second dispatch after RETI -> o_Vector=16'h0060.
- IME=0, IE=8'h01, request 0 -> o_Wake=1 and no o_Handle_Interrupt at i_Boundary.
- i_EI, then i_Boundary with request 0 pending -> no dispatch. Next i_Boundary -> dispatch to 16'h0040. Repeat with i_EI and i_DI together -> IME stays 0.
- With IC_LATE_VECTOR_EN, dispatch on bit 0, write IE=8'h00 before i_Ack -> o_Vector=16'h0000, IF bit 0 still set. Without the macro, the same stimulus gives o_Vector=16'h0040.
- Assert i_Reset_n low in VECTOR -> all outputs reset asynchronously, o_IF=8'hE0. i_Request[3] in the same cycle as an i_Ack clearing bit 3 -> bit 3 remains set.

Source files
------------

// File: rtl/gb_int_pkg.sv
// -----------------------------------------------------------------------------
// gb_int_pkg
// Shared definitions for the interrupt controller: dispatch FSM state encoding,
// interrupt source bit positions, vector base/stride constants and a helper
// that turns a source index into its vector address.
// Optional build macro used by the controller: IC_LATE_VECTOR_EN.
// -----------------------------------------------------------------------------
package gb_int_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        VECTOR   = 2'd2
    } int_state_e;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;

    localparam logic [15:0] INT_VEC_BASE   = 16'h0040;
    localparam logic [15:0] INT_VEC_STRIDE = 16'h0008;

    // Vector address of source idx: base + stride * idx.
    function automatic logic [15:0] int_vector(input logic [15:0] base,
                                               input logic [2:0]  idx);
        int_vector = base + ({13'd0, idx} * INT_VEC_STRIDE);
    endfunction

endpackage

// File: rtl/int_priority_encoder.sv
// -----------------------------------------------------------------------------
// int_priority_encoder
// Picks the lowest set bit of the request vector (bit 0 = highest priority).
// Ports:
//   req     in  WIDTH  pending request bits
//   onehot  out WIDTH  one-hot winner (all zero when nothing pending)
//   index   out 3      index of the winner (0 when nothing pending)
//   valid   out 1      at least one request bit set
// -----------------------------------------------------------------------------
module int_priority_encoder #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic [2:0]       index,
    output logic             valid
);

    // Lowest-index set bit wins; later (higher) bits are ignored once found.
    always_comb begin
        onehot = {WIDTH{1'b0}};
        index  = 3'd0;
        valid  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i] && !valid) begin
                onehot[i] = 1'b1;
                index     = 3'(i);
                valid     = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Holds IE, IF and IME, latches peripheral requests, and hands the highest
// priority pending interrupt to the control unit at instruction boundaries
// through a Handle/Ack/Done handshake. Also produces the HALT wake signal.
//
// Build macro IC_LATE_VECTOR_EN:
//   defined   - winner chosen at i_Ack; dispatch can be cancelled (vector 0000)
//   undefined - winner latched and its IF bit cleared when dispatch starts
//
// Ports:
//   i_Clk, i_Reset_n          clock, async active-low reset
//   i_Enable                  T-cycle enable gating every state update
//   i_Request[4:0]            peripheral request pulses (set IF bits)
//   i_Data, i_IF_Write,
//   i_IE_Write                register write port for IF / IE
//   o_IF, o_IE                register read values (o_IF upper bits read 1)
//   i_EI, i_DI, i_RETI        IME control from the executing instruction
//   i_Boundary                instruction-boundary pulse
//   i_Ack, i_Done             dispatch handshake from the control unit
//   o_Handle_Interrupt        dispatch requested
//   o_Vector                  jump target, valid in VECTOR
//   o_Wake                    any enabled interrupt flagged (ignores IME)
// -----------------------------------------------------------------------------
module interrupt_controller
    import gb_int_pkg::*;
#(
    parameter int          NUM_SRC  = 5,
    parameter logic [15:0] VEC_BASE = INT_VEC_BASE
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic               i_Enable,
    input  logic [NUM_SRC-1:0] i_Request,
    input  logic [7:0]         i_Data,
    input  logic               i_IF_Write,
    input  logic               i_IE_Write,
    output logic [7:0]         o_IF,
    output logic [7:0]         o_IE,
    input  logic               i_EI,
    input  logic               i_DI,
    input  logic               i_RETI,
    input  logic               i_Boundary,
    input  logic               i_Ack,
    input  logic               i_Done,
    output logic               o_Handle_Interrupt,
    output logic [15:0]        o_Vector,
    output logic               o_Wake
);

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_DISPATCH = DISPATCH;
    localparam logic [1:0] ST_VECTOR   = VECTOR;

    logic [7:0]         ie_r;
    logic [NUM_SRC-1:0] if_r;
    logic [NUM_SRC-1:0] if_nxt_s;
    logic               ime_r;
    logic               ime_nxt_s;
    logic               ei_pending_r;
    logic               ei_pending_nxt_s;
    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic               handle_r;
    logic               handle_nxt_s;
    logic [15:0]        vector_r;
    logic [15:0]        vector_nxt_s;
    logic               dispatch_go_s;
    logic [NUM_SRC-1:0] clear_mask_s;

    logic [NUM_SRC-1:0] pending_s;
    logic [NUM_SRC-1:0] win_onehot_s;
    logic [2:0]         win_idx_s;
    logic               win_valid_s;
`ifdef IC_LATE_VECTOR_EN
`else
    logic [2:0]         win_idx_r;
`endif

    assign pending_s = ie_r[NUM_SRC-1:0] & if_r;

    int_priority_encoder #(
        .WIDTH (NUM_SRC)
    ) u_prio (
        .req    (pending_s),
        .onehot (win_onehot_s),
        .index  (win_idx_s),
        .valid  (win_valid_s)
    );

    // Dispatch FSM: next state, handle flag, vector load and IF clear mask.
    always_comb begin
        state_nxt_s   = state_r;
        handle_nxt_s  = handle_r;
        vector_nxt_s  = vector_r;
        clear_mask_s  = {NUM_SRC{1'b0}};
        dispatch_go_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Old IME is used here, so an EI promoted at this same
                // boundary cannot trigger a dispatch yet.
                if (i_Boundary && ime_r && win_valid_s) begin
                    dispatch_go_s = 1'b1;
                    state_nxt_s   = ST_DISPATCH;
                    handle_nxt_s  = 1'b1;
`ifdef IC_LATE_VECTOR_EN
`else
                    clear_mask_s  = win_onehot_s;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (i_Ack) begin
                    state_nxt_s  = ST_VECTOR;
                    handle_nxt_s = 1'b0;
`ifdef IC_LATE_VECTOR_EN
                    // Pending is re-evaluated now; it may have vanished
                    // (e.g. IE overwritten by the PC push) -> cancel.
                    if (win_valid_s) begin
                        vector_nxt_s = int_vector(VEC_BASE, win_idx_s);
                        clear_mask_s = win_onehot_s;
                    end else begin
                        vector_nxt_s = 16'h0000;
                    end
`else
                    vector_nxt_s = int_vector(VEC_BASE, win_idx_r);
`endif
                end else begin
                    state_nxt_s = ST_DISPATCH;
                end
            end
            ST_VECTOR: begin
                if (i_Done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_VECTOR;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                handle_nxt_s = 1'b0;
            end
        endcase
    end

    // IF next value: write, then ack clear, then requests (requests win).
    always_comb begin
        if_nxt_s = if_r;
        if (i_IF_Write) begin
            if_nxt_s = i_Data[NUM_SRC-1:0];
        end else begin
            if_nxt_s = if_r;
        end
        if_nxt_s = (if_nxt_s & ~clear_mask_s) | i_Request;
    end

    // IME / EI-delay next value; DI has the last word over EI, RETI, dispatch.
    always_comb begin
        ime_nxt_s        = ime_r;
        ei_pending_nxt_s = ei_pending_r;
        if (i_Boundary && ei_pending_r) begin
            ime_nxt_s        = 1'b1;
            ei_pending_nxt_s = 1'b0;
        end else begin
            ime_nxt_s = ime_r;
        end
        if (i_EI) begin
            ei_pending_nxt_s = 1'b1;
        end else begin
            ei_pending_nxt_s = ei_pending_nxt_s;
        end
        if (i_RETI) begin
            ime_nxt_s = 1'b1;
        end else begin
            ime_nxt_s = ime_nxt_s;
        end
        if (dispatch_go_s) begin
            ime_nxt_s = 1'b0;
        end else begin
            ime_nxt_s = ime_nxt_s;
        end
        if (i_DI) begin
            ime_nxt_s        = 1'b0;
            ei_pending_nxt_s = 1'b0;
        end else begin
            ime_nxt_s = ime_nxt_s;
        end
    end

    // State registers; everything holds while i_Enable is low.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ie_r         <= 8'h00;
            if_r         <= {NUM_SRC{1'b0}};
            ime_r        <= 1'b0;
            ei_pending_r <= 1'b0;
            state_r      <= ST_IDLE;
            handle_r     <= 1'b0;
            vector_r     <= 16'h0000;
        end else if (i_Enable) begin
            if (i_IE_Write) begin
                ie_r <= i_Data;
            end
            if_r         <= if_nxt_s;
            ime_r        <= ime_nxt_s;
            ei_pending_r <= ei_pending_nxt_s;
            state_r      <= state_nxt_s;
            handle_r     <= handle_nxt_s;
            vector_r     <= vector_nxt_s;
        end
    end

`ifdef IC_LATE_VECTOR_EN
`else
    // Winner index captured when dispatch starts, used for the vector at ack.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            win_idx_r <= 3'd0;
        end else if (i_Enable && dispatch_go_s) begin
            win_idx_r <= win_idx_s;
        end
    end
`endif

    assign o_IF               = {{(8 - NUM_SRC){1'b1}}, if_r};
    assign o_IE               = ie_r;
    assign o_Handle_Interrupt = handle_r;
    assign o_Vector           = vector_r;
    assign o_Wake             = |pending_s;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
// Directed, table-driven bench for interrupt_controller, plus hand-written
// sequences for dispatch cancellation, request-vs-clear and async reset.
// Expectations depend on IC_LATE_VECTOR_EN where the two builds differ.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

`ifdef IC_LATE_VECTOR_EN
    localparam bit LATE = 1'b1;
`else
    localparam bit LATE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [4:0]  req;
    logic [7:0]  data;
    logic        ifw, iew, ei, di, reti, bnd, ack, done;
    logic [7:0]  o_if, o_ie;
    logic        o_hi, o_wake;
    logic [15:0] o_vec;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .i_Clk              (clk),
        .i_Reset_n          (rst_n),
        .i_Enable           (en),
        .i_Request          (req),
        .i_Data             (data),
        .i_IF_Write         (ifw),
        .i_IE_Write         (iew),
        .o_IF               (o_if),
        .o_IE               (o_ie),
        .i_EI               (ei),
        .i_DI               (di),
        .i_RETI             (reti),
        .i_Boundary         (bnd),
        .i_Ack              (ack),
        .i_Done             (done),
        .o_Handle_Interrupt (o_hi),
        .o_Vector           (o_vec),
        .o_Wake             (o_wake)
    );

    typedef struct {
        logic        en;
        logic [4:0]  req;
        logic [7:0]  data;
        logic        ifw, iew, ei, di, reti, bnd, ack, done;
        logic [7:0]  e_if;
        logic [7:0]  e_ie;
        logic        e_hi;
        logic [15:0] e_vec;
        logic        e_wake;
    } vec_t;

    function automatic vec_t mk(input logic a_en, input logic [4:0] a_req,
                                input logic [7:0] a_data, input logic a_ifw,
                                input logic a_iew, input logic a_ei,
                                input logic a_di, input logic a_reti,
                                input logic a_bnd, input logic a_ack,
                                input logic a_done, input logic [7:0] x_if,
                                input logic [7:0] x_ie, input logic x_hi,
                                input logic [15:0] x_vec, input logic x_wake);
        vec_t v;
        v.en = a_en;   v.req = a_req;   v.data = a_data;
        v.ifw = a_ifw; v.iew = a_iew;   v.ei = a_ei;     v.di = a_di;
        v.reti = a_reti; v.bnd = a_bnd; v.ack = a_ack;   v.done = a_done;
        v.e_if = x_if; v.e_ie = x_ie;   v.e_hi = x_hi;
        v.e_vec = x_vec; v.e_wake = x_wake;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, return just after rise.
    task automatic drive(input vec_t v);
        @(negedge clk);
        en = v.en;   req = v.req;   data = v.data;
        ifw = v.ifw; iew = v.iew;   ei = v.ei;   di = v.di;
        reti = v.reti; bnd = v.bnd; ack = v.ack; done = v.done;
        @(posedge clk);
        #1;
    endtask

    // Enabled cycle with don't-care expectations (for hand sequences).
    task automatic cyc(input logic [4:0] r, input logic [7:0] d,
                       input logic fw, input logic ew, input logic e_i,
                       input logic d_i, input logic rt, input logic b,
                       input logic a, input logic dn);
        drive(mk(1'b1, r, d, fw, ew, e_i, d_i, rt, b, a, dn,
                 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0));
    endtask

    vec_t tbl[34];

    initial begin
        rst_n = 1'b0; en = 1'b1; req = 5'd0; data = 8'd0;
        ifw = 1'b0; iew = 1'b0; ei = 1'b0; di = 1'b0;
        reti = 1'b0; bnd = 1'b0; ack = 1'b0; done = 1'b0;

        //            en   req     data  ifw  iew  ei   di   reti bnd  ack  done   IF                      IE     HI    VEC       WAKE
        // IE=05, request timer, dispatch to 0050
        tbl[0]  = mk(1'b1, 5'h00, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE0, 8'h05, 1'b0, 16'h0000, 1'b0);
        tbl[1]  = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hE0, 8'h05, 1'b0, 16'h0000, 1'b0);
        tbl[2]  = mk(1'b1, 5'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE4, 8'h05, 1'b0, 16'h0000, 1'b1);
        tbl[3]  = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, LATE ? 8'hE4 : 8'hE0, 8'h05, 1'b1, 16'h0000, LATE);
        tbl[4]  = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 8'h05, 1'b0, 16'h0050, 1'b0);
        tbl[5]  = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE0, 8'h05, 1'b0, 16'h0050, 1'b0);
        // IME now 0: pending request must not dispatch
        tbl[6]  = mk(1'b1, 5'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE4, 8'h05, 1'b0, 16'h0050, 1'b1);
        tbl[7]  = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hE4, 8'h05, 1'b0, 16'h0050, 1'b1);
        tbl[8]  = mk(1'b1, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE0, 8'h05, 1'b0, 16'h0050, 1'b0);
        // IE=1F, joypad+STAT together: STAT first (0048), joypad after RETI (0060)
        tbl[9]  = mk(1'b1, 5'h00, 8'h1F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hE0, 8'h1F, 1'b0, 16'h0050, 1'b0);
        tbl[10] = mk(1'b1, 5'h12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF2, 8'h1F, 1'b0, 16'h0050, 1'b1);
        tbl[11] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, LATE ? 8'hF2 : 8'hF0, 8'h1F, 1'b1, 16'h0050, 1'b1);
        tbl[12] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h1F, 1'b0, 16'h0048, 1'b1);
        tbl[13] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h1F, 1'b0, 16'h0048, 1'b1);
        tbl[14] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h1F, 1'b0, 16'h0048, 1'b1);
        tbl[15] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, LATE ? 8'hF0 : 8'hE0, 8'h1F, 1'b1, 16'h0048, LATE);
        tbl[16] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 8'h1F, 1'b0, 16'h0060, 1'b0);
        tbl[17] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE0, 8'h1F, 1'b0, 16'h0060, 1'b0);
        // IME=0, IE=01, VBlank: wake but no dispatch
        tbl[18] = mk(1'b1, 5'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE0, 8'h01, 1'b0, 16'h0060, 1'b0);
        tbl[19] = mk(1'b1, 5'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE1, 8'h01, 1'b0, 16'h0060, 1'b1);
        tbl[20] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hE1, 8'h01, 1'b0, 16'h0060, 1'b1);
        // EI: first boundary promotes only, second dispatches to 0040
        tbl[21] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE1, 8'h01, 1'b0, 16'h0060, 1'b1);
        tbl[22] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hE1, 8'h01, 1'b0, 16'h0060, 1'b1);
        tbl[23] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, LATE ? 8'hE1 : 8'hE0, 8'h01, 1'b1, 16'h0060, LATE);
        tbl[24] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 8'h01, 1'b0, 16'h0040, 1'b0);
        tbl[25] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE0, 8'h01, 1'b0, 16'h0040, 1'b0);
        // EI and DI together: IME stays 0
        tbl[26] = mk(1'b1, 5'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE1, 8'h01, 1'b0, 16'h0040, 1'b1);
        tbl[27] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE1, 8'h01, 1'b0, 16'h0040, 1'b1);
        tbl[28] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hE1, 8'h01, 1'b0, 16'h0040, 1'b1);
        tbl[29] = mk(1'b1, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hE1, 8'h01, 1'b0, 16'h0040, 1'b1);
        // Disabled cycle: write and request ignored
        tbl[30] = mk(1'b0, 5'h08, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE1, 8'h01, 1'b0, 16'h0040, 1'b1);
        tbl[31] = mk(1'b1, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE0, 8'h01, 1'b0, 16'h0040, 1'b0);
        // Request beats same-cycle IF write of that bit
        tbl[32] = mk(1'b1, 5'h04, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE4, 8'h01, 1'b0, 16'h0040, 1'b0);
        tbl[33] = mk(1'b1, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE0, 8'h01, 1'b0, 16'h0040, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.if",   {8'h00, o_if}, 16'h00E0);
        check("rst.ie",   {8'h00, o_ie}, 16'h0000);
        check("rst.hi",   {15'd0, o_hi}, 16'h0000);
        check("rst.vec",  o_vec,         16'h0000);
        check("rst.wake", {15'd0, o_wake}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 34; i++) begin
            drive(tbl[i]);
            check($sformatf("v%0d.if", i),   {8'h00, o_if},   {8'h00, tbl[i].e_if});
            check($sformatf("v%0d.ie", i),   {8'h00, o_ie},   {8'h00, tbl[i].e_ie});
            check($sformatf("v%0d.hi", i),   {15'd0, o_hi},   {15'd0, tbl[i].e_hi});
            check($sformatf("v%0d.vec", i),  o_vec,           tbl[i].e_vec);
            check($sformatf("v%0d.wake", i), {15'd0, o_wake}, {15'd0, tbl[i].e_wake});
        end

        // Cancellation: IE cleared between dispatch start and ack
        //  req    data   ifw   iew   ei    di    reti  bnd   ack   done
        cyc(5'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("cancel.hi", {15'd0, o_hi}, 16'h0001);
        cyc(5'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("cancel.vec", o_vec, LATE ? 16'h0000 : 16'h0040);
        check("cancel.if", {8'h00, o_if}, LATE ? 16'h00E1 : 16'h00E0);
        check("cancel.hi_low", {15'd0, o_hi}, 16'h0000);
        cyc(5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Serial request held through the cycle that clears bit 3
        cyc(5'h00, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("req_clr.hi", {15'd0, o_hi}, 16'h0001);
        cyc(5'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("req_clr.vec", o_vec, 16'h0058);
        check("req_clr.if", {8'h00, o_if}, 16'h00E8);

        // Asynchronous reset while in VECTOR
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.if",   {8'h00, o_if},   16'h00E0);
        check("arst.ie",   {8'h00, o_ie},   16'h0000);
        check("arst.hi",   {15'd0, o_hi},   16'h0000);
        check("arst.vec",  o_vec,           16'h0000);
        check("arst.wake", {15'd0, o_wake}, 16'h0000);
        req = 5'd0; ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // IME back to 0 after reset: no dispatch
        cyc(5'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst.hi",   {15'd0, o_hi},   16'h0000);
        check("post_rst.wake", {15'd0, o_wake}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
